// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounce_sync input conditioner.
`timescale 1ns/1ps
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    WAIT_HIGH = 2'b01,
    ST_HIGH   = 2'b11,
    WAIT_LOW  = 2'b10
  } db_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
`timescale 1ns/1ps
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw level, emitting rise/fall pulses and a rising-edge count.
`timescale 1ns/1ps
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clr_count,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count
);

  localparam int              RUN_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  db_state_t        state, state_nx;
  logic [RUN_W-1:0] cnt, cnt_nx;
  logic             accept_rise, accept_fall;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (s)
  );

  // A WAIT state counts agreeing samples; a single disagreeing sample drops back.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    case (state)
      ST_LOW: begin
        if (s) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = RUN_W'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nx = ST_LOW;
          cnt_nx   = '0;
        end else if (cnt == RUN_LAST) begin
          state_nx    = ST_HIGH;
          cnt_nx      = '0;
          accept_rise = 1'b1;
        end else begin
          cnt_nx = cnt + RUN_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_nx = WAIT_LOW;
          cnt_nx   = RUN_W'(1);
        end else begin
          cnt_nx   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nx = ST_HIGH;
          cnt_nx   = '0;
        end else if (cnt == RUN_LAST) begin
          state_nx    = ST_LOW;
          cnt_nx      = '0;
          accept_fall = 1'b1;
        end else begin
          cnt_nx = cnt + RUN_W'(1);
        end
      end
      default: begin
        state_nx = ST_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The count moves on the accepting edge, so a coincident clear keeps that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_count <= '0;
    end else begin
      rise <= accept_rise;
      fall <= accept_fall;
      if (accept_rise) begin
        dout <= 1'b1;
      end else if (accept_fall) begin
        dout <= 1'b0;
      end
      if (accept_rise) begin
        edge_count <= clr_count ? CNT_W'(1) : edge_count + CNT_W'(1);
      end else if (clr_count) begin
        edge_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync with a run-length reference model.
`timescale 1ns/1ps
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 8;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          din       = 1'b0;
  logic          clr_count = 1'b0;
  logic          dout, rise, fall;
  logic [CW-1:0] edge_count;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_sync #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .clr_count  (clr_count),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .edge_count (edge_count)
  );

  always #1 clk = ~clk;

  // Reference: din delayed SYNC edges gives s; dout flips after DEB consecutive s samples that disagree with it.
  logic [SYNC-1:0] m_delay = '0;
  logic            m_dout  = 1'b0;
  logic            m_rise  = 1'b0;
  logic            m_fall  = 1'b0;
  int              m_run   = 0;
  logic [CW-1:0]   m_count = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_delay <= '0;
      m_dout  <= 1'b0;
      m_rise  <= 1'b0;
      m_fall  <= 1'b0;
      m_run   <= 0;
      m_count <= '0;
    end else begin : model_step
      logic          s_v, d_v, r_v, f_v;
      int            run_v;
      logic [CW-1:0] c_v;
      s_v   = m_delay[SYNC-1];
      d_v   = m_dout;
      r_v   = 1'b0;
      f_v   = 1'b0;
      run_v = (s_v != m_dout) ? m_run + 1 : 0;
      if (run_v == DEB) begin
        d_v   = s_v;
        r_v   = s_v;
        f_v   = !s_v;
        run_v = 0;
      end
      c_v = m_count;
      if (r_v) c_v = clr_count ? CW'(1) : m_count + CW'(1);
      else if (clr_count) c_v = '0;
      m_delay <= {m_delay[SYNC-2:0], din};
      m_dout  <= d_v;
      m_rise  <= r_v;
      m_fall  <= f_v;
      m_run   <= run_v;
      m_count <= c_v;
    end
  end

  task automatic apply_reset();
    reset     = 1'b0;
    din       = 1'b0;
    clr_count = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    din   = 1'b1;
    clr_count = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dout, rise, fall, edge_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got dout=%b rise=%b fall=%b cnt=%0d, need all 0", dout, rise, fall, edge_count);
      end
    end
    apply_reset();
  endtask

  task automatic test_clean_step();
    logic [CW+2:0] exp_v;
    apply_reset();
    @(negedge clk);
    din = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_v = {(i >= 6) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0, (i >= 6) ? CW'(1) : CW'(0)};
      n_checks++;
      if ({dout, rise, fall, edge_count} !== exp_v) begin
        n_fail++;
        $display("FAIL clean_rise edge %0d: got %b, need %b", i, {dout, rise, fall, edge_count}, exp_v);
      end
      n_checks++;
      if ({dout, rise, fall, edge_count} !== {m_dout, m_rise, m_fall, m_count}) begin
        n_fail++;
        $display("FAIL clean_rise_model edge %0d: got %b, need %b", i, {dout, rise, fall, edge_count}, {m_dout, m_rise, m_fall, m_count});
      end
    end
    din = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_v = {(i >= 6) ? 1'b0 : 1'b1, 1'b0, (i == 6) ? 1'b1 : 1'b0, CW'(1)};
      n_checks++;
      if ({dout, rise, fall, edge_count} !== exp_v) begin
        n_fail++;
        $display("FAIL clean_fall edge %0d: got %b, need %b", i, {dout, rise, fall, edge_count}, exp_v);
      end
    end
  endtask

  task automatic test_bounce_reject();
    logic pat [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      din = (i < 7) ? pat[i] : 1'b0;
      n_checks++;
      if ({dout, rise, fall, edge_count} !== '0 ||
          {dout, rise, fall, edge_count} !== {m_dout, m_rise, m_fall, m_count}) begin
        n_fail++;
        $display("FAIL bounce_reject cycle %0d: got %b, need all 0", i, {dout, rise, fall, edge_count});
      end
    end
  endtask

  task automatic test_bounce_settle();
    int rises = 0;
    apply_reset();
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j > 1) begin
        n_checks++;
        if (dout !== ((j - 1) >= 9) || rise !== ((j - 1) == 9) || dout !== m_dout) begin
          n_fail++;
          $display("FAIL bounce_settle edge %0d: got dout=%b rise=%b, need dout=%b rise=%b",
                   j - 1, dout, rise, (j - 1) >= 9, (j - 1) == 9);
        end
        if (rise) rises++;
      end
      din = (j == 3) ? 1'b0 : 1'b1;
    end
    n_checks++;
    if (rises != 1 || edge_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL bounce_settle_count: got rises=%0d cnt=%0d, need 1 and 1", rises, edge_count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_checks++;
      if ({dout, rise, fall, edge_count} !== {m_dout, m_rise, m_fall, m_count} || (rise & fall)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b, need %b", c, {dout, rise, fall, edge_count}, {m_dout, m_rise, m_fall, m_count});
      end
      if ($urandom_range(0, 3) == 0) din = ~din;
      clr_count = ($urandom_range(0, 15) == 0);
    end
    clr_count = 1'b0;
  endtask

  task automatic test_wrap_clear();
    apply_reset();
    for (int p = 0; p < 258; p++) begin
      for (int h = 0; h < 12; h++) begin
        din = (h < 6);
        @(negedge clk);
        n_checks++;
        if ({dout, rise, fall, edge_count} !== {m_dout, m_rise, m_fall, m_count}) begin
          n_fail++;
          $display("FAIL wrap_model pulse %0d: got %b, need %b", p, {dout, rise, fall, edge_count}, {m_dout, m_rise, m_fall, m_count});
        end
      end
      if (p == 255) begin
        n_checks++;
        if (edge_count !== '0) begin
          n_fail++;
          $display("FAIL wrap_256: got cnt=%0d, need 0", edge_count);
        end
      end
    end
    n_checks++;
    if (edge_count !== CW'(2)) begin
      n_fail++;
      $display("FAIL wrap_258: got cnt=%0d, need 2", edge_count);
    end
    din = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      clr_count = (i == 5);
    end
    n_checks++;
    if (edge_count !== CW'(1) || rise !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_rise: got cnt=%0d rise=%b, need 1 and 1", edge_count, rise);
    end
    din = 1'b0;
    repeat (8) @(negedge clk);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    n_checks++;
    if (edge_count !== '0) begin
      n_fail++;
      $display("FAIL clr_alone: got cnt=%0d, need 0", edge_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    din = 1'b1;
    repeat (8) @(negedge clk);
    din = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (edge_count !== CW'(1) || dout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got cnt=%0d dout=%b, need 1 and 0", edge_count, dout);
    end
    din = 1'b1;
    repeat (5) @(negedge clk);
    #0.5 reset = 1'b0;
    #0.1;
    n_checks++;
    if ({dout, rise, fall, edge_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b, need all 0", {dout, rise, fall, edge_count});
    end
    din = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dout, rise, fall, edge_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_after %0d: got %b, need all 0", i, {dout, rise, fall, edge_count});
      end
    end
  endtask

  task automatic test_release_high();
    reset = 1'b0;
    din   = 1'b1;
    clr_count = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== (i >= 6) || rise !== (i == 6) || edge_count !== ((i >= 6) ? CW'(1) : CW'(0))) begin
        n_fail++;
        $display("FAIL release_high edge %0d: got dout=%b rise=%b cnt=%0d, need dout=%b rise=%b cnt=%0d",
                 i, dout, rise, edge_count, i >= 6, i == 6, (i >= 6) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce_reject();
    test_bounce_settle();
    test_random();
    test_wrap_clear();
    test_reset_mid();
    test_release_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
